// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator.
//   - btn_state_t : per-button FSM state (IDLE / DOWN / HELD)
//   - EVT_*       : 2-bit event codes presented on evt_code
//   - max_u       : constant helper used to size the hold counter
package button_event_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DOWN = 2'd1,
      ST_HELD = 2'd2
   } btn_state_t;

   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_RELEASE = 2'd1;
   localparam logic [1:0] EVT_LONG    = 2'd2;
   localparam logic [1:0] EVT_REPEAT  = 2'd3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_gen_sync_fifo.sv
// Synchronous FIFO used as the event queue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   rdata        head entry, forced to zero while empty
//   full, empty  occupancy flags
module button_event_gen_sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_pop_s  = pop & ~empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push_s = push & (~full | do_pop_s);
   assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

   // Storage write; data needs no reset because rdata is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

   // Read and write pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: converts debounced button levels into PRESS, RELEASE,
// LONG and REPEAT events, queued through a FIFO to a valid/ready consumer.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   btn           debounced button levels, 1 = pressed
//   evt_valid     FIFO head valid
//   evt_ready     consumer accepts head when evt_valid & evt_ready
//   evt_btn       button index of head event
//   evt_code      0=PRESS 1=RELEASE 2=LONG 3=REPEAT
//   overflow      sticky: an event was dropped
//   clr_overflow  synchronous clear of overflow (a new drop wins)
module button_event_gen
   import button_event_gen_pkg::*;
#(
   parameter  int NUM_BTN       = 4,
   parameter  int LONG_CYCLES   = 5000000,
   parameter  int REPEAT_CYCLES = 1000000,
   parameter  int FIFO_DEPTH    = 8,
   localparam int IDW           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDW-1:0]     evt_btn,
   output logic [1:0]         evt_code,
   output logic               overflow,
   input  logic               clr_overflow
);

   localparam int CW = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [NUM_BTN-1:0]      pend_v_s;
   logic [NUM_BTN-1:0][1:0] pend_code_s;
   logic [NUM_BTN-1:0]      grant_s;
   logic [NUM_BTN-1:0]      drop_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic                    fifo_pop_s;
   logic                    can_write_s;
   logic                    push_s;
   logic [IDW-1:0]          win_idx_s;
   logic [1:0]              win_code_s;
   logic                    overflow_r;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_state_t    state_r;
      btn_state_t    state_nxt_s;
      logic [CW-1:0] cnt_r;
      logic [CW-1:0] cnt_nxt_s;
      logic          emit_s;
      logic [1:0]    emit_code_s;
      logic          pend_v_r;
      logic [1:0]    pend_code_r;

      // Next-state logic; a release always takes priority over LONG/REPEAT.
      always_comb begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
         emit_s      = 1'b0;
         emit_code_s = EVT_PRESS;
         case (state_r)
            ST_IDLE: begin
               if (btn[i]) begin
                  emit_s      = 1'b1;
                  emit_code_s = EVT_PRESS;
                  state_nxt_s = ST_DOWN;
                  cnt_nxt_s   = {CW{1'b0}};
               end else begin
                  cnt_nxt_s   = {CW{1'b0}};
               end
            end
            ST_DOWN: begin
               if (!btn[i]) begin
                  emit_s      = 1'b1;
                  emit_code_s = EVT_RELEASE;
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CW{1'b0}};
               end else if (cnt_r == LONG_LAST) begin
                  emit_s      = 1'b1;
                  emit_code_s = EVT_LONG;
                  state_nxt_s = ST_HELD;
                  cnt_nxt_s   = {CW{1'b0}};
               end else begin
                  cnt_nxt_s   = cnt_r + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (!btn[i]) begin
                  emit_s      = 1'b1;
                  emit_code_s = EVT_RELEASE;
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CW{1'b0}};
               end else if ((REPEAT_CYCLES != 0) && (cnt_r == REP_LAST)) begin
                  emit_s      = 1'b1;
                  emit_code_s = EVT_REPEAT;
                  cnt_nxt_s   = {CW{1'b0}};
               end else if (cnt_r != CNT_MAX) begin
                  // With REPEAT disabled the counter parks at its maximum.
                  cnt_nxt_s   = cnt_r + CNT_ONE;
               end else begin
                  cnt_nxt_s   = cnt_r;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CW{1'b0}};
            end
         endcase
      end

      // FSM state and hold counter registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
         end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
         end
      end

      // A new event is lost only if the slot is occupied and not drained now.
      assign drop_s[i] = emit_s & pend_v_r & ~grant_s[i];

      // Pending slot: refill wins over drain, so drain+refill keeps the slot full.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend_v_r    <= 1'b0;
            pend_code_r <= EVT_PRESS;
         end else if (emit_s && !drop_s[i]) begin
            pend_v_r    <= 1'b1;
            pend_code_r <= emit_code_s;
         end else if (grant_s[i]) begin
            pend_v_r    <= 1'b0;
         end else begin
            pend_v_r    <= pend_v_r;
         end
      end

      assign pend_v_s[i]    = pend_v_r;
      assign pend_code_s[i] = pend_code_r;
   end

   assign fifo_pop_s  = ~fifo_empty_s & evt_ready;
   assign can_write_s = ~fifo_full_s | fifo_pop_s;

   // Fixed-priority arbiter: lowest-index pending slot wins one FIFO write.
   always_comb begin
      grant_s    = {NUM_BTN{1'b0}};
      push_s     = 1'b0;
      win_idx_s  = {IDW{1'b0}};
      win_code_s = EVT_PRESS;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (can_write_s && pend_v_s[i] && !push_s) begin
            grant_s[i] = 1'b1;
            push_s     = 1'b1;
            win_idx_s  = IDW'(i);
            win_code_s = pend_code_s[i];
         end else begin
            grant_s[i] = 1'b0;
         end
      end
   end

   // Sticky overflow flag; a drop in the clear cycle keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (|drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_overflow) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign overflow = overflow_r;

   button_event_gen_sync_fifo #(
      .WIDTH (IDW + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata ({win_idx_s, win_code_s}),
      .pop   (fifo_pop_s),
      .rdata ({evt_btn, evt_code}),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign evt_valid = ~fifo_empty_s;

endmodule

// File: tb/tb_button_event_gen.sv
module tb_button_event_gen;

   typedef struct {
      logic [1:0] b;
      logic [1:0] c;
      int         t;
   } exp_t;

   localparam logic [1:0] P  = 2'd0;
   localparam logic [1:0] R  = 2'd1;
   localparam logic [1:0] L  = 2'd2;
   localparam logic [1:0] RP = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn, btn_b;
   logic       ready, clr;
   logic       v0, ov0, v1, ov1;
   logic [1:0] b0, c0, b1, c1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q0[$];
   exp_t q1[$];

   button_event_gen #(.NUM_BTN(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn(btn), .evt_valid(v0), .evt_ready(ready),
      .evt_btn(b0), .evt_code(c0), .overflow(ov0), .clr_overflow(clr));

   button_event_gen #(.NUM_BTN(4), .LONG_CYCLES(8), .REPEAT_CYCLES(0), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn(btn_b), .evt_valid(v1), .evt_ready(1'b1),
      .evt_btn(b1), .evt_code(c1), .overflow(ov1), .clr_overflow(1'b0));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp0(input logic [1:0] b, input logic [1:0] c, input int t);
      exp_t e;
      e.b = b; e.c = c; e.t = t;
      q0.push_back(e);
   endtask

   task automatic exp1(input logic [1:0] b, input logic [1:0] c, input int t);
      exp_t e;
      e.b = b; e.c = c; e.t = t;
      q1.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
      chk("drain_pending0", q0.size(), 0);
      chk("drain_pending1", q1.size(), 0);
      tick(3);
   endtask

   // Monitor for dut0: a handshake seen at the negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && v0 && ready) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_event", {28'd0, b0, c0}, -1);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("dut0_event", {28'd0, b0, c0}, {28'd0, e.b, e.c});
            if (e.t >= 0) chk("dut0_event_time", cyc, e.t);
         end
      end
   end

   // Monitor for dut1 (always ready).
   always @(negedge clk) begin
      if (rst_n && v1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_event", {28'd0, b1, c1}, -1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("dut1_event", {28'd0, b1, c1}, {28'd0, e.b, e.c});
            if (e.t >= 0) chk("dut1_event_time", cyc, e.t);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0; btn = 4'd0; btn_b = 4'd0; ready = 1'b1; clr = 1'b0;
      #1;
      chk("reset_valid", v0, 0);
      chk("reset_btn", b0, 0);
      chk("reset_code", c0, 0);
      chk("reset_overflow", ov0, 0);
      chk("reset_valid1", v1, 0);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // 1: short press, no LONG
      n = cyc;
      btn[0] = 1'b1;
      exp0(2'd0, P, n + 2);
      tick(3);
      btn[0] = 1'b0;
      exp0(2'd0, R, n + 5);
      drain();
      chk("t1_overflow", ov0, 0);

      // 2: long hold with repeats; repeat at release edge suppressed
      n = cyc;
      btn[2] = 1'b1;
      exp0(2'd2, P, n + 2);
      exp0(2'd2, L, n + 10);
      exp0(2'd2, RP, n + 14);
      exp0(2'd2, RP, n + 18);
      tick(20);
      btn[2] = 1'b0;
      exp0(2'd2, R, n + 22);
      drain();

      // 3: simultaneous presses resolve by fixed priority
      n = cyc;
      btn[1] = 1'b1; btn[3] = 1'b1;
      exp0(2'd1, P, n + 2);
      exp0(2'd3, P, n + 3);
      tick(4);
      n = cyc;
      btn[1] = 1'b0; btn[3] = 1'b0;
      exp0(2'd1, R, n + 2);
      exp0(2'd3, R, n + 3);
      drain();

      // 4: overflow with stalled consumer
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         btn[0] = 1'b1; tick(1);
         btn[0] = 1'b0; tick(1);
      end
      exp0(2'd0, P, -1); exp0(2'd0, R, -1); exp0(2'd0, P, -1);
      exp0(2'd0, R, -1); exp0(2'd0, P, -1);
      tick(3);
      chk("t4_overflow_set", ov0, 1);
      chk("t4_valid_stalled", v0, 1);
      ready = 1'b1;
      drain();
      chk("t4_overflow_sticky", ov0, 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("t4_overflow_cleared", ov0, 0);

      // 5: reset while held, button still down when reset releases
      n = cyc;
      btn[0] = 1'b1;
      exp0(2'd0, P, n + 2);
      exp0(2'd0, L, -1);
      tick(10);
      chk("t5_valid_before_reset", v0, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_valid_in_reset", v0, 0);
      chk("t5_overflow_in_reset", ov0, 0);
      chk("t5_code_in_reset", c0, 0);
      void'(q0.pop_back());
      tick(2);
      rst_n = 1'b1;
      n = cyc;
      exp0(2'd0, P, n + 2);
      tick(3);
      btn[0] = 1'b0;
      exp0(2'd0, R, -1);
      drain();

      // 6: REPEAT disabled instance
      n = cyc;
      btn_b[0] = 1'b1;
      exp1(2'd0, P, n + 2);
      exp1(2'd0, L, n + 10);
      tick(30);
      btn_b[0] = 1'b0;
      exp1(2'd0, R, n + 32);
      drain();
      chk("t6_overflow", ov1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
